module_alu_shift_l_seq: RTL and testbench
=========================================

MODULE_ALU_SHIFT_L_SEQ -- requirements
Module: module_alu_shift_l_seq

Interface
REQ-001 The block SHALL have parameter BITS_WIDTH, default taken from pkg_bits::BITS_WIDTH, giving the operand width W.
REQ-002 The block SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start_i, input, 1 bit: request a new shift; sampled only in IDLE.
REQ-005 The block SHALL have port ALUA_i, input, pkg_bits::bits_t (W bits): operand to shift.
REQ-006 The block SHALL have port ALUB_i, input, pkg_bits::bits_t (W bits): unsigned shift amount.
REQ-007 The block SHALL have port ALUFlagIn_i, input, 1 bit: fill bit shifted into the LSB.
REQ-008 The block SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port done_o, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port ALUResult_o, output, pkg_bits::bitsw_t (W+1 bits): {carry, shifted value}.

Function
REQ-011 The block SHALL implement a left shift, one bit per clock, with three states: IDLE, SHIFT and DONE.
REQ-012 In IDLE with start_i=1, the block SHALL latch three values at the same edge: shift register = ALUA_i, carry = 0, fill = ALUFlagIn_i.
REQ-013 At the same edge it SHALL load count = min(ALUB_i, W+1), saturating so that latency is bounded.
REQ-014 After the load, the next state SHALL be SHIFT if count != 0, otherwise DONE.
REQ-015 Each SHIFT cycle SHALL update {carry, reg} <= {reg, fill} and decrement count.
REQ-016 SHIFT SHALL go to DONE on the cycle in which count goes from 1 to 0.
REQ-017 Carry SHALL equal the last bit shifted out of the MSB; the result SHALL match the combinational {carry, A} << B with fill-bit insertion, truncated to W+1 bits.
REQ-018 For B >= W+1 (saturated count), the result SHALL be all bits equal to the fill bit, including carry.
REQ-019 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-020 Latency SHALL be N+1 cycles from the start-accept edge to the done_o=1 cycle, where N = min(B, W+1).
REQ-021 ALUResult_o SHALL be driven from registers, valid from the DONE cycle, and held unchanged in IDLE until the next accepted start.
REQ-022 start_i asserted while busy_o=1 SHALL be ignored, with no queuing.
REQ-023 ALUA_i, ALUB_i and ALUFlagIn_i changes after the accept edge SHALL NOT affect the operation in flight.
REQ-024 start_i=1 in the same cycle that DONE returns to IDLE SHALL NOT be accepted; it is accepted in the following IDLE cycle if still high.
REQ-025 busy_o and done_o SHALL be combinational decodes of the state register only.

Reset
REQ-026 rst_n_i=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, count=0, carry=0, shift register=0 and fill=0.
REQ-027 During reset the outputs SHALL read busy_o=0, done_o=0 and ALUResult_o=0.
REQ-028 Reset asserted mid-operation SHALL abort it with no done_o pulse; the first start after rst_n_i deasserts SHALL be accepted normally.

Verification (W=4)
REQ-029 Basic shift: A=1011, B=2, fill=0, start -> done_o on the 3rd cycle after accept, ALUResult_o=01100, busy_o high for 3 cycles.
REQ-030 Fill insertion: A=0001, B=3, fill=1 -> ALUResult_o=01111 with done_o 4 cycles after accept.
REQ-031 Zero shift: A=1010, B=0 -> state goes IDLE->DONE, done_o 1 cycle after accept, ALUResult_o=01010.
REQ-032 Saturation: A=1111, B=1111, fill=0 -> count=5, ALUResult_o=00000 after 6 cycles; the same with fill=1 -> 11111.
REQ-033 Protocol: start_i pulsed while busy_o=1, plus input changes mid-operation -> no effect on the result or latency, no second done_o.
REQ-034 Reset: rst_n_i low during SHIFT, between clock edges -> busy_o=0 and ALUResult_o=0 immediately, no done_o; the next operation completes correctly.

Source files
------------

// File: rtl/module_alu_shift_l_seq.sv
// Purpose: bit-serial left shifter, one bit per clock, with a fill bit and a carry-out of the last MSB.
// Latency: N+1 cycles from start accept to the done_o cycle, N = min(ALUB_i, W+1).
// Backpressure: none; start_i is sampled only in IDLE, ignored while busy, never queued.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   start_i             request a shift (honoured only in IDLE)
//   ALUA_i, ALUB_i      operand and unsigned shift amount
//   ALUFlagIn_i         bit shifted into the LSB on every step
//   busy_o, done_o      state decodes: not-IDLE, and the one-cycle DONE pulse
//   ALUResult_o         registered {carry, shifted value}

package pkg_bits;
  localparam int BITS_WIDTH = 4;
  typedef logic [BITS_WIDTH-1:0] bits_t;
  typedef logic [BITS_WIDTH:0]   bitsw_t;
endpackage

module module_alu_shift_l_seq #(
  parameter int BITS_WIDTH = pkg_bits::BITS_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [BITS_WIDTH-1:0] ALUA_i,
  input  logic [BITS_WIDTH-1:0] ALUB_i,
  input  logic                  ALUFlagIn_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [BITS_WIDTH:0]   ALUResult_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Shifting W+1 or more positions flushes every original bit, carry included,
  // so the count saturates there to bound the latency.
  localparam int unsigned MAX_SHIFT = BITS_WIDTH + 1;
  localparam logic [BITS_WIDTH:0] CNT_MAX = MAX_SHIFT[BITS_WIDTH:0];
  localparam logic [BITS_WIDTH:0] CNT_ONE = {{BITS_WIDTH{1'b0}}, 1'b1};
  localparam logic [BITS_WIDTH:0] CNT_ZERO = '0;

  state_t                state;
  logic [BITS_WIDTH:0]   cnt;
  logic [BITS_WIDTH-1:0] sreg;
  logic                  carry;
  logic                  fill;

  logic [BITS_WIDTH:0]   cnt_load;

  // Count width is W+1 so both the raw amount and the saturation value fit.
  always_comb begin
    cnt_load = {1'b0, ALUB_i};
    if ({1'b0, ALUB_i} >= CNT_MAX) begin
      cnt_load = CNT_MAX;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      fill  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            sreg  <= ALUA_i;
            carry <= 1'b0;
            fill  <= ALUFlagIn_i;
            cnt   <= cnt_load;
            state <= (cnt_load == CNT_ZERO) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          {carry, sreg} <= {sreg, fill};
          cnt           <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Always return to IDLE; a start seen here waits for the IDLE cycle.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign ALUResult_o = {carry, sreg};

endmodule

// File: tb/tb_module_alu_shift_l_seq.sv
// Directed bench for the bit-serial left shifter at W=4.
// Each operation checks result, latency to done_o, busy cycles and single done pulse.
// Also covers reset values, mid-operation reset and start held across DONE.

module tb_module_alu_shift_l_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic       flag_in;
  logic       busy;
  logic       done;
  logic [4:0] result;

  int tests_run;
  int tests_failed;

  module_alu_shift_l_seq #(.BITS_WIDTH(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .start_i     (start),
    .ALUA_i      (alu_a),
    .ALUB_i      (alu_b),
    .ALUFlagIn_i (flag_in),
    .busy_o      (busy),
    .done_o      (done),
    .ALUResult_o (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Launch one operation and watch it for a fixed window after the accept edge.
  // Cycle k=1 is the state right after the accept edge; done_o is expected at k=exp_lat.
  // With disturb set, inputs are scrambled and start is pulsed while busy.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic f, input logic [4:0] exp_res, input int exp_lat,
                       input bit disturb);
    int lat;
    int done_cnt;
    int busy_cnt;
    logic [4:0] res_at_done;
    lat = 0; done_cnt = 0; busy_cnt = 0; res_at_done = '0;
    @(negedge clk);
    alu_a = a; alu_b = b; flag_in = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin
          lat = k;
          res_at_done = result;
        end
      end
      if (disturb) begin
        if (k == 1) begin
          alu_a = ~a; alu_b = 4'd0; flag_in = ~f; start = 1'b1;
        end else if (k == 2) begin
          start = 1'b0;
        end
      end
    end
    check({tag, "_result"}, 32'(res_at_done), 32'(exp_res));
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_held_idle"}, 32'(result), 32'(exp_res));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    start = 1'b0; alu_a = '0; alu_b = '0; flag_in = 1'b0;
    rst_n = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // {0,1011}<<2 -> 01100
    do_op("basic", 4'b1011, 4'd2, 1'b0, 5'b01100, 3, 1'b0);
    // 00001 with three ones shifted in -> 01111
    do_op("fill", 4'b0001, 4'd3, 1'b1, 5'b01111, 4, 1'b0);
    // no shift: IDLE->DONE
    do_op("zero", 4'b1010, 4'd0, 1'b0, 5'b01010, 1, 1'b0);
    // 10101 after a single step with fill=1
    do_op("one", 4'b1010, 4'd1, 1'b1, 5'b10101, 2, 1'b0);
    // shift by W: only the LSB survives, landing in the carry
    do_op("by_w", 4'b0011, 4'd4, 1'b0, 5'b10000, 5, 1'b0);
    // B=15 saturates to 5 steps
    do_op("sat0", 4'b1111, 4'b1111, 1'b0, 5'b00000, 6, 1'b0);
    do_op("sat1", 4'b1111, 4'b1111, 1'b1, 5'b11111, 6, 1'b0);
    // B=W+1 exactly
    do_op("sat_edge", 4'b0101, 4'd5, 1'b1, 5'b11111, 6, 1'b0);
    // 01011 -> 10110 -> 01100 -> 11000 despite mid-op changes
    do_op("protocol", 4'b1011, 4'd3, 1'b0, 5'b11000, 4, 1'b1);

    // start held high through DONE: re-accepted only in the following IDLE cycle
    @(negedge clk);
    alu_a = 4'b0110; alu_b = 4'd0; flag_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("hold_k1_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("hold_k2_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("hold_k3_done", 32'(done), 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_end_busy", 32'(busy), 32'd0);

    // reset asserted between edges during SHIFT
    @(negedge clk);
    alu_a = 4'b1111; alu_b = 4'd3; flag_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("mid_rst_hold_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst", 4'b1001, 4'd2, 1'b1, 5'b00111, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
